// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP         = 32'h0000_0013;

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StKill
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response and decode hand-off signals of the fetch unit.
interface pc_fetch_unit_if #(
    parameter int unsigned XLEN = fetch_pkg::XLEN
) ();
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            if_valid;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic            if_ready;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output if_valid, if_instr, if_pc,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  if_valid, if_instr, if_pc,
        output if_ready
    );
endinterface

// File: rtl/fetch_buffer.sv
// Small FIFO of {pc, instruction} pairs between instruction memory and decode.
module fetch_buffer #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 32,
    localparam int unsigned AddrW = $clog2(Depth),
    localparam int unsigned CntW  = AddrW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [Width-1:0] push_pc_i,
    input  logic [Width-1:0] push_instr_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CntW-1:0]  count_o,
    output logic             valid_o,
    output logic [Width-1:0] head_pc_o,
    output logic [Width-1:0] head_instr_o
);
    import fetch_pkg::*;

    logic [Width-1:0] pc_mem_q [Depth];
    logic [Width-1:0] pc_mem_d [Depth];
    logic [Width-1:0] instr_mem_q [Depth];
    logic [Width-1:0] instr_mem_d [Depth];
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             pop_en;

    always_comb begin
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        pop_en      = pop_i && (count_q != '0);
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                pc_mem_d[wr_ptr_q]    = push_pc_i;
                instr_mem_d[wr_ptr_q] = push_instr_i;
                wr_ptr_d              = wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push_i, pop_en})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(Depth); i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    assign count_o      = count_q;
    assign valid_o      = (count_q != '0);
    assign head_pc_o    = pc_mem_q[rd_ptr_q];
    assign head_instr_o = instr_mem_q[rd_ptr_q];

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch front end: owns the PC, issues one imem read at a time, buffers results for decode
// and applies branch/jump redirects.
module pc_fetch_unit #(
    parameter int unsigned     XLEN      = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    pc_fetch_unit_if.master bus
);
    import fetch_pkg::*;

    localparam int unsigned CntW = $clog2(BUF_DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            active_q;
    logic [CntW-1:0] buf_count;
    logic            buf_full, buf_push, buf_pop, req_accept;

    assign buf_full = (buf_count == CntW'(BUF_DEPTH));
    assign buf_pop  = bus.if_valid && bus.if_ready;

    always_comb begin
        state_d            = state_q;
        fetch_pc_d         = fetch_pc_q;
        req_pc_d           = req_pc_q;
        buf_push           = 1'b0;
        // active_q keeps the request line low for the first cycle out of reset
        bus.imem_req_valid = active_q && (state_q == StReq) && !buf_full;
        req_accept         = bus.imem_req_valid && bus.imem_req_ready;

        unique case (state_q)
            StReq: begin
                if (req_accept) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (bus.imem_resp_valid) begin
                    buf_push = !redirect_valid;
                    state_d  = StReq;
                end
            end
            StKill: begin
                if (bus.imem_resp_valid) begin
                    state_d = StReq;
                end
            end
            default: state_d = StReq;
        endcase

        // A request still in flight after the redirect must have its response swallowed
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~XLEN'(INSTR_BYTES - 1);
            if (req_accept || ((state_q != StReq) && !bus.imem_resp_valid)) begin
                state_d = StKill;
            end else begin
                state_d = StReq;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StReq;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            active_q   <= 1'b1;
        end
    end

    assign bus.imem_req_addr = fetch_pc_q;

    fetch_buffer #(
        .Depth (BUF_DEPTH),
        .Width (XLEN)
    ) u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (buf_push),
        .push_pc_i    (req_pc_q),
        .push_instr_i (bus.imem_resp_data),
        .pop_i        (buf_pop),
        .flush_i      (redirect_valid),
        .count_o      (buf_count),
        .valid_o      (bus.if_valid),
        .head_pc_o    (bus.if_pc),
        .head_instr_o (bus.if_instr)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a memory model answers requests, a monitor checks decode output.
module tb_pc_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] ResetPc = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_acc = 0;
    int          lat = 1;
    int          wait_cnt = 0;
    logic [31:0] last_acc_addr = '0;
    logic [31:0] pend_data = '0;
    logic        prev_hold = 1'b0;
    logic [31:0] held_pc = '0;
    logic [31:0] held_instr = '0;
    exp_t        mon_e;
    int          base;

    pc_fetch_unit_if #(.XLEN(32)) bus ();

    pc_fetch_unit #(
        .XLEN      (32),
        .RESET_PC  (ResetPc),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    // Memory contents: word at address a is a + 0x1000_0013
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h1000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr);
        exp_q.push_back('{pc: pc, instr: instr});
    endtask

    // Called at a falling edge; advances one clock and plays the memory side.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        #1;
        acc = bus.imem_req_valid && bus.imem_req_ready;
        a   = bus.imem_req_addr;
        @(negedge clk);
        bus.imem_resp_valid = 1'b0;
        if (acc) begin
            n_acc++;
            last_acc_addr = a;
            pend_data     = mem_word(a);
            wait_cnt      = lat;
        end
        if (wait_cnt > 0) begin
            wait_cnt--;
            if (wait_cnt == 0) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = pend_data;
            end
        end
    endtask

    task automatic run_fetches(input int n, input string name, input logic [31:0] want_addr);
        int target;
        int budget;
        target = n_acc + n;
        budget = 40;
        bus.imem_req_ready = 1'b1;
        while (n_acc < target && budget > 0) begin
            tick();
            budget--;
        end
        bus.imem_req_ready = 1'b0;
        check({name, "_accepts"}, 32'(n_acc), 32'(target));
        check(name, last_acc_addr, want_addr);
    endtask

    task automatic drain(input string name);
        repeat (5) tick();
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
        check({tag, "_req_addr"}, bus.imem_req_addr, ResetPc);
        check({tag, "_if_valid"}, 32'(bus.if_valid), 32'd0);
        check({tag, "_if_instr"}, bus.if_instr, 32'd0);
        check({tag, "_if_pc"}, bus.if_pc, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #2;
        reset_checks(tag);
        @(negedge clk);
        bus.imem_resp_valid = 1'b0;
        wait_cnt = 0;
        rst_n = 1'b1;
    endtask

    // Monitor: samples just before each rising edge
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_pc", bus.if_pc, held_pc);
                    check("hold_instr", bus.if_instr, held_instr);
                end
                if (redirect_valid) begin
                    exp_q.delete();
                end else if (bus.if_valid && bus.if_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_pop: got pc %h instr %h, expected no instruction",
                                 bus.if_pc, bus.if_instr);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("pop_pc", bus.if_pc, mon_e.pc);
                        check("pop_instr", bus.if_instr, mon_e.instr);
                    end
                end
                prev_hold  = bus.if_valid && !bus.if_ready && !redirect_valid;
                held_pc    = bus.if_pc;
                held_instr = bus.if_instr;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.if_ready        = 1'b0;

        // Reset state, then three in-order fetches
        #1 rst_n = 1'b0;
        #2 reset_checks("rst");
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(32'h0000_0000, 32'h1000_0013);
        push_exp(32'h0000_0004, 32'h1000_0017);
        push_exp(32'h0000_0008, 32'h1000_001B);
        bus.if_ready = 1'b1;
        run_fetches(1, "t1_a0", 32'h0000_0000);
        run_fetches(1, "t1_a1", 32'h0000_0004);
        run_fetches(1, "t1_a2", 32'h0000_0008);
        drain("t1_drain");

        // Decode stalled: buffer fills after two requests, head held
        do_reset("t2_rst");
        bus.if_ready = 1'b0;
        push_exp(32'h0000_0000, 32'h1000_0013);
        push_exp(32'h0000_0004, 32'h1000_0017);
        push_exp(32'h0000_0008, 32'h1000_001B);
        base = n_acc;
        bus.imem_req_ready = 1'b1;
        repeat (12) tick();
        bus.imem_req_ready = 1'b0;
        check("t2_reqs", 32'(n_acc - base), 32'd2);
        check("t2_req_valid_full", 32'(bus.imem_req_valid), 32'd0);
        check("t2_if_valid", 32'(bus.if_valid), 32'd1);
        check("t2_head_pc", bus.if_pc, 32'h0000_0000);
        bus.if_ready = 1'b1;
        run_fetches(1, "t2_resume", 32'h0000_0008);
        drain("t2_drain");

        // Redirect while waiting on memory with a non-empty buffer
        bus.if_ready = 1'b0;
        lat = 1;
        run_fetches(1, "t3_pre_a", 32'h0000_000C);
        lat = 3;
        run_fetches(1, "t3_pre_b", 32'h0000_0010);
        check("t3_buf_nonempty", 32'(bus.if_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        bus.if_ready   = 1'b1;
        tick();
        redirect_valid = 1'b0;
        check("t3_flush", 32'(bus.if_valid), 32'd0);
        check("t3_kill_no_req", 32'(bus.imem_req_valid), 32'd0);
        lat = 1;
        push_exp(32'h0000_0100, 32'h1000_0113);
        run_fetches(1, "t3_target", 32'h0000_0100);
        drain("t3_drain");

        // Unaligned redirect target from REQ, no request accepted
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        tick();
        redirect_valid = 1'b0;
        check("t4_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("t4_addr", bus.imem_req_addr, 32'h0000_0200);
        push_exp(32'h0000_0200, 32'h1000_0213);
        run_fetches(1, "t4_target", 32'h0000_0200);
        drain("t4_drain");

        // Redirect in the same cycle as the response: data dropped, no KILL
        run_fetches(1, "t5_pre", 32'h0000_0204);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        tick();
        redirect_valid = 1'b0;
        check("t5_no_kill", 32'(bus.imem_req_valid), 32'd1);
        check("t5_addr", bus.imem_req_addr, 32'h0000_0300);
        push_exp(32'h0000_0300, 32'h1000_0313);
        run_fetches(1, "t5_target", 32'h0000_0300);
        drain("t5_drain");

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        push_exp(32'hFFFF_FFFC, 32'h1000_000F);
        push_exp(32'h0000_0000, 32'h1000_0013);
        run_fetches(1, "t6_top", 32'hFFFF_FFFC);
        run_fetches(1, "t6_wrap", 32'h0000_0000);
        drain("t6_drain");

        // Asynchronous reset mid-WAIT; the late response must be ignored
        lat = 3;
        run_fetches(1, "t6_pre", 32'h0000_0004);
        #2 rst_n = 1'b0;
        #1 reset_checks("t6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        check("t6_stray_ignored", 32'(bus.if_valid), 32'd0);
        check("t6_restart_addr", bus.imem_req_addr, ResetPc);
        lat = 1;
        push_exp(32'h0000_0000, 32'h1000_0013);
        run_fetches(1, "t6_restart", 32'h0000_0000);
        drain("t6_final_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
